// File: rtl/coin_credit_pkg.sv
// Shared types and the 7-segment digit table for the coin credit display.
// Segment patterns are listed p[0..6] = segments a..g, active-high.
package coin_credit_pkg;

    typedef logic [3:0] credit_t;
    typedef logic [4:0] sum_t;

    localparam logic [0:6] SEG_DIGIT [0:9] = '{
        7'b1111110,
        7'b0110000,
        7'b1101101,
        7'b1111001,
        7'b0110011,
        7'b1011011,
        7'b1011111,
        7'b1110000,
        7'b1111111,
        7'b1111011
    };

    // Shown for codes 10..15, which the credit register never holds.
    localparam logic [0:6] SEG_BLANK = 7'b0000001;

endpackage

// File: rtl/seg7_decoder.sv
// Credit value to single-digit 7-segment pattern.
// SEG_ACTIVE_LOW_EN inverts every segment for common-anode displays.
module seg7_decoder
    import coin_credit_pkg::*;
(
    input  credit_t    value,
    output logic [0:6] seg
);

    logic [0:6] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        if (value <= credit_t'(9)) begin
            pattern = SEG_DIGIT[value];
        end
    end

`ifdef SEG_ACTIVE_LOW_EN
    assign seg = ~pattern;
`else
    assign seg = pattern;
`endif

endmodule

// File: rtl/coin_credit_display.sv
// Coin-accumulating vend controller: counts one coin per rising edge on a/b/c,
// vends (c1) and returns change (c2) at PRICE. Display polarity: SEG_ACTIVE_LOW_EN.
module coin_credit_display
    import coin_credit_pkg::*;
#(
    parameter int PRICE = 10,
    parameter int VAL_A = 1,
    parameter int VAL_B = 2,
    parameter int VAL_C = 5
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [0:6] p,
    output logic       c1,
    output logic       c2
);

    credit_t credit;
    logic    prev_a;
    logic    prev_b;
    logic    prev_c;
    logic    rise_a;
    logic    rise_b;
    logic    rise_c;
    logic    any_rise;
    sum_t    sum;

    assign rise_a   = a & ~prev_a;
    assign rise_b   = b & ~prev_b;
    assign rise_c   = c & ~prev_c;
    assign any_rise = rise_a | rise_b | rise_c;

    // Simultaneous coins all land in the same cycle; worst case 9 + 8 fits 5 bits.
    always_comb begin
        sum = sum_t'(credit);
        if (rise_a) sum = sum + sum_t'(VAL_A);
        if (rise_b) sum = sum + sum_t'(VAL_B);
        if (rise_c) sum = sum + sum_t'(VAL_C);
    end

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            credit <= '0;
            c1     <= 1'b0;
            c2     <= 1'b0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
            prev_c <= 1'b0;
        end else begin
            prev_a <= a;
            prev_b <= b;
            prev_c <= c;
            if (!any_rise) begin
                c1 <= 1'b0;
                c2 <= 1'b0;
            end else if (sum >= sum_t'(PRICE)) begin
                // Overpayment is refunded as change rather than carried forward.
                credit <= '0;
                c1     <= 1'b1;
                c2     <= (sum > sum_t'(PRICE));
            end else begin
                credit <= credit_t'(sum);
                c1     <= 1'b0;
                c2     <= 1'b0;
            end
        end
    end

    seg7_decoder u_seg (
        .value (credit),
        .seg   (p)
    );

endmodule

// File: tb/tb_coin_credit_display.sv
// Scoreboard bench for coin_credit_display: a coin-level reference model queues
// the expected state after every clock edge and a monitor compares the DUT.
module tb_coin_credit_display;

    localparam int PRICE = 10;
    localparam int COIN_VAL [0:2] = '{1, 2, 5};

    typedef struct packed {
        logic [3:0] credit;
        logic       vend;
        logic       change;
    } expect_t;

    logic       ck;
    logic       rs;
    logic       a;
    logic       b;
    logic       c;
    logic [0:6] p;
    logic       c1;
    logic       c2;

    expect_t expq[$];
    int      checks;
    int      errors;

    int      mcredit;
    logic    mprev [0:2];

    coin_credit_display #(
        .PRICE (10),
        .VAL_A (1),
        .VAL_B (2),
        .VAL_C (5)
    ) dut (
        .ck (ck),
        .rs (rs),
        .a  (a),
        .b  (b),
        .c  (c),
        .p  (p),
        .c1 (c1),
        .c2 (c2)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [0:6] expSeg(input int value);
        logic [0:6] s;
        case (value)
            0: s = 7'b1111110;
            1: s = 7'b0110000;
            2: s = 7'b1101101;
            3: s = 7'b1111001;
            4: s = 7'b0110011;
            5: s = 7'b1011011;
            6: s = 7'b1011111;
            7: s = 7'b1110000;
            8: s = 7'b1111111;
            9: s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
`ifdef SEG_ACTIVE_LOW_EN
        s = ~s;
`endif
        return s;
    endfunction

    // Reference: tally newly inserted coins, vend at PRICE, refund any excess.
    always @(posedge ck) begin
        expect_t e;
        int      total;
        logic    lev [0:2];
        lev[0] = a;
        lev[1] = b;
        lev[2] = c;
        if (!rs) begin
            mcredit = 0;
            for (int i = 0; i < 3; i++) mprev[i] = 1'b0;
            e = '{credit: 4'd0, vend: 1'b0, change: 1'b0};
        end else begin
            total = mcredit;
            for (int i = 0; i < 3; i++) begin
                if (lev[i] && !mprev[i]) total += COIN_VAL[i];
                mprev[i] = lev[i];
            end
            if (total >= PRICE) begin
                e = '{credit: 4'd0, vend: 1'b1, change: (total > PRICE)};
                mcredit = 0;
            end else begin
                mcredit = total;
                e = '{credit: 4'(total), vend: 1'b0, change: 1'b0};
            end
        end
        expq.push_back(e);
    end

    task automatic checkOutput(input string name, input expect_t e);
        checks++;
        if (p !== expSeg(int'(e.credit)) || c1 !== e.vend || c2 !== e.change) begin
            errors++;
            $display("[TB] FAIL %s at %0t: p=%b c1=%b c2=%b, expected p=%b c1=%b c2=%b",
                     name, $time, p, c1, c2, expSeg(int'(e.credit)), e.vend, e.change);
        end
    endtask

    // Monitor samples 2 time units after each edge, well clear of the edge itself.
    always begin
        @(posedge ck);
        #2;
        if (expq.size() > 0) checkOutput("cycle", expq.pop_front());
    end

    task automatic applyStimulus(input logic va, input logic vb, input logic vc, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ck);
            a = va;
            b = vb;
            c = vc;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rs = 1'b0;
        a  = 1'b0;
        b  = 1'b0;
        c  = 1'b0;

        // Reset, then release with all inputs low.
        repeat (3) @(negedge ck);
        rs = 1'b1;
        applyStimulus(0, 0, 0, 3);

        // One long coin on a counts once.
        applyStimulus(1, 0, 0, 4);
        applyStimulus(0, 0, 0, 2);

        // b,a,b,a,idle,b,c: credit 2,3,5,6,6,8 then vend with change.
        applyStimulus(0, 1, 0, 2);
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 0, 0, 2);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 0, 3);

        // b, c, c: 2, 7, then sum 12 vends with change.
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 0, 2);

        // Exact payment: c, c gives 10 with no change.
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 0, 2);

        // All three coins in one cycle: +8, no vend.
        applyStimulus(1, 1, 1, 2);
        applyStimulus(0, 0, 0, 2);

        // Push to a vend, then abort the pulse with an asynchronous reset.
        applyStimulus(0, 0, 1, 1);
        @(negedge ck);
        rs = 1'b0;
        c  = 1'b0;
        #1;
        checkOutput("async_reset", '{credit: 4'd0, vend: 1'b0, change: 1'b0});
        applyStimulus(0, 0, 0, 2);
        rs = 1'b1;

        // Input already high when reset releases counts at the first edge.
        applyStimulus(0, 0, 0, 1);
        rs = 1'b0;
        applyStimulus(0, 1, 0, 1);
        rs = 1'b1;
        applyStimulus(0, 1, 0, 3);
        applyStimulus(0, 0, 0, 2);

        // Randomized coins with held levels and occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] lv;
            @(negedge ck);
            if ($urandom_range(0, 1) == 0) begin
                lv = 3'($urandom_range(0, 7));
                a  = lv[2];
                b  = lv[1];
                c  = lv[0];
            end
            rs = ($urandom_range(0, 49) != 0);
        end
        rs = 1'b1;
        applyStimulus(0, 0, 0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
